sysop_unit: RTL and testbench
=============================

// Module: sysop_unit
// PURPOSE
// Sequential system-op/CSR execution unit for the RV32 core. Accepts one SYSTEM-opcode instruction
// per valid/ready handshake and decodes it (MRET/ECALL/EBREAK/WFI/Zicsr). Runs CSR read-modify-write
// over a req/ack CSR bus, with a bus timeout, and parks in WFI until an interrupt is pending.
// Reports each instruction with a single o_done pulse carrying rd write-back, trap cause, or mret.
// PARAMETERS
// XLEN         32  data width of rs1, CSR and rd values
// ENABLE_WFI   1   1: WFI (0x10500073) supported; 0: WFI traps as illegal
// CSR_TIMEOUT  16  cycles in READ/WRITE without ack before illegal trap; 0 disables timeout
// PORTS
// i_clk          in   1     clock
// i_rst          in   1     reset, asynchronous, active-high
// i_valid        in   1     i_inst/i_rs1_data valid
// o_ready        out  1     unit can accept (IDLE & !i_flush & !i_rst)
// i_inst         in   32    instruction word
// i_rs1_data     in   XLEN  rs1 operand
// i_flush        in   1     abort current instruction (pipeline flush)
// i_irq_pending  in   1     wake condition for WFI
// o_done         out  1     one-cycle completion pulse; all result outputs valid with it
// o_rd_we        out  1     write o_rd_data to o_rd_addr (only with o_done)
// o_rd_addr      out  5     destination register
// o_rd_data      out  XLEN  old CSR value
// o_trap         out  1     instruction traps (with o_done)
// o_cause        out  4     2 illegal, 3 breakpoint, 11 ecall-M
// o_mret         out  1     MRET completed (with o_done)
// o_wfi          out  1     high while parked in WFI
// o_csr_req      out  1     CSR bus request, held until i_csr_ack
// o_csr_we       out  1     1 write, 0 read
// o_csr_addr     out  12    CSR address = inst[31:20]
// o_csr_wdata    out  XLEN  write data
// i_csr_ack      in   1     CSR bus acknowledge
// i_csr_rdata    in   XLEN  read data, valid with ack on a read
// i_csr_err      in   1     nonexistent/read-only CSR, valid with ack
// BEHAVIOUR
// - Reset: state IDLE, all outputs 0, counter 0, flush_pending 0.
// - Accept on i_valid & o_ready; latch inst, operand = inst[14] ? zext(inst[19:15]) : i_rs1_data.
// - Decode: 0x30200073 MRET; 0x00000073 ECALL; 0x00100073 EBREAK; 0x10500073 WFI; opcode 1110011 with
//   funct3 001/101 RW, 010/110 RS, 011/111 RC; everything else (incl. funct3 000/100 other) illegal.
// - Read needed: RS/RC always, RW only if rd!=x0. Write needed: RW always, RS/RC only if inst[19:15]!=0.
// - States: IDLE, READ, WRITE, WFI, DONE.
//   IDLE -> DONE (illegal/ECALL/EBREAK/MRET), -> WFI, -> READ (read needed), -> WRITE (write only).
//   READ: req=1 we=0; on ack: err -> DONE illegal; else old=rdata, -> WRITE if write needed else DONE.
//   WRITE: req=1 we=1, wdata = RW:op, RS:old|op, RC:old&~op; on ack -> DONE (err -> illegal).
//   WFI: o_wfi=1; i_irq_pending -> DONE (no trap, no rd write).
//   DONE: o_done=1 one cycle, -> IDLE. o_ready=0 in DONE.
// - req/we/addr/wdata stable from first request cycle until ack; req drops the cycle after ack.
// - Timeout: counter clears on entering READ/WRITE, increments each unacked cycle; count==CSR_TIMEOUT-1
//   without ack -> DONE illegal, req dropped. Ack in the same cycle as expiry wins.
// - o_rd_we = o_done & CSR op & rd!=x0 & !o_trap; o_rd_data = old CSR value.
// - Latency: non-CSR accept at T -> o_done T+1. Write-only with ack in T+1 -> o_done T+2.
//   Read+write with immediate acks -> o_done T+3.
// - Flush: IDLE/READ/WFI -> IDLE next cycle, no o_done (reads are side-effect free). WRITE: set
//   flush_pending, finish the write, then IDLE with o_done suppressed. DONE: o_done suppressed.
//   i_flush with i_valid in IDLE: not accepted.
// - Reset mid-operation: immediate return to IDLE, req deasserted, no o_done.
// TESTING
// - CSRRS x5,mstatus(0x300),x6; rs1=0x8, rdata=0x1800 -> write 0x1808, o_rd_data=0x1800, rd=5.
// - CSRRW x0,0x305,x1 = 0x100 -> no read cycle, single write wdata=0x100, o_rd_we=0, o_done at T+2.
// - CSRRCI x3,0x344,0 -> read only, no write request, o_rd_data=i_csr_rdata, rd=3.
// - i_csr_ack held low with CSR_TIMEOUT=16 -> req 16 cycles, then o_trap=1, o_cause=2.
// - ECALL -> o_cause=11 at T+1; EBREAK -> 3; MRET -> o_mret=1; 0xFFFFFFFF -> o_cause=2.
// - WFI, irq at +5 -> o_wfi 5 cycles, then o_done. i_flush during WRITE -> write completes, no o_done.

Source files
------------

// File: rtl/sysop_unit.sv
// SYSTEM-opcode unit (MRET/ECALL/EBREAK/WFI/Zicsr): decodes one instruction per handshake and runs the CSR read-modify-write.
// Latency: 1 cycle for non-CSR ops, plus one cycle per CSR bus access. o_ready is high only in IDLE; bus requests are held until ack.
module sysop_unit #(
  parameter int XLEN        = 32,
  parameter bit ENABLE_WFI  = 1'b1,
  parameter int CSR_TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic            i_flush,
  input  logic            i_irq_pending,
  output logic            o_done,
  output logic            o_rd_we,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_trap,
  output logic [3:0]      o_cause,
  output logic            o_mret,
  output logic            o_wfi,
  output logic            o_csr_req,
  output logic            o_csr_we,
  output logic [11:0]     o_csr_addr,
  output logic [XLEN-1:0] o_csr_wdata,
  input  logic            i_csr_ack,
  input  logic [XLEN-1:0] i_csr_rdata,
  input  logic            i_csr_err
);
  localparam int CW = (CSR_TIMEOUT > 1) ? $clog2(CSR_TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_WFI, S_DONE} state_t;

  state_t          state;
  logic [1:0]      kind_q;
  logic            need_wr_q;
  logic [XLEN-1:0] op_q;
  logic [CW-1:0]   cnt;
  logic            flush_pending;
  logic            done_q, trap_q, mret_q, rd_we_q;
  logic [3:0]      cause_q;

  // Decode straight off the input word; only meaningful when accepting.
  logic [2:0]      f3;
  logic [4:0]      d_rd, d_rs1;
  logic            is_csr, is_mret, is_ecall, is_ebreak, is_wfi, need_rd_d, need_wr_d;
  logic [XLEN-1:0] op_d;
  logic            accept, expire;

  assign f3        = i_inst[14:12];
  assign d_rd      = i_inst[11:7];
  assign d_rs1     = i_inst[19:15];
  assign is_csr    = (i_inst[6:0] == 7'b1110011) && (f3[1:0] != 2'b00);
  assign is_mret   = (i_inst == 32'h3020_0073);
  assign is_ecall  = (i_inst == 32'h0000_0073);
  assign is_ebreak = (i_inst == 32'h0010_0073);
  assign is_wfi    = ENABLE_WFI && (i_inst == 32'h1050_0073);
  assign need_rd_d = is_csr && ((f3[1:0] != 2'b01) || (d_rd != 5'd0));
  assign need_wr_d = is_csr && ((f3[1:0] == 2'b01) || (d_rs1 != 5'd0));
  assign op_d      = i_inst[14] ? XLEN'(d_rs1) : i_rs1_data;

  assign o_ready = (state == S_IDLE) && !i_flush && !i_rst;
  assign accept  = i_valid && o_ready;
  assign expire  = (CSR_TIMEOUT != 0) && (cnt == CW'(CSR_TIMEOUT - 1));

  assign o_done  = done_q && !i_flush;
  assign o_rd_we = o_done && rd_we_q;
  assign o_trap  = o_done && trap_q;
  assign o_mret  = o_done && mret_q;
  assign o_cause = o_done ? cause_q : 4'd0;
  assign o_wfi   = (state == S_WFI);

  function automatic logic [XLEN-1:0] rmw(input logic [1:0] k, input logic [XLEN-1:0] old,
                                          input logic [XLEN-1:0] op);
    case (k)
      2'b10:   rmw = old | op;
      2'b11:   rmw = old & ~op;
      default: rmw = op;
    endcase
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      kind_q        <= 2'b00;
      need_wr_q     <= 1'b0;
      op_q          <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
      done_q        <= 1'b0;
      trap_q        <= 1'b0;
      mret_q        <= 1'b0;
      rd_we_q       <= 1'b0;
      cause_q       <= 4'd0;
      o_rd_addr     <= 5'd0;
      o_rd_data     <= '0;
      o_csr_req     <= 1'b0;
      o_csr_we      <= 1'b0;
      o_csr_addr    <= 12'd0;
      o_csr_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          flush_pending <= 1'b0;
          if (accept) begin
            kind_q     <= f3[1:0];
            need_wr_q  <= need_wr_d;
            op_q       <= op_d;
            o_rd_addr  <= d_rd;
            o_rd_data  <= '0;
            o_csr_addr <= i_inst[31:20];
            cnt        <= '0;
            if (need_rd_d) begin
              state     <= S_READ;
              o_csr_req <= 1'b1;
              o_csr_we  <= 1'b0;
            end else if (is_csr) begin
              // Only CSRRW/CSRRWI with rd=x0 skip the read, so the write data is the operand.
              state       <= S_WRITE;
              o_csr_req   <= 1'b1;
              o_csr_we    <= 1'b1;
              o_csr_wdata <= op_d;
            end else if (is_wfi) begin
              state <= S_WFI;
            end else begin
              state   <= S_DONE;
              done_q  <= 1'b1;
              mret_q  <= is_mret;
              trap_q  <= !is_mret;
              cause_q <= is_ecall ? 4'd11 : (is_ebreak ? 4'd3 : (is_mret ? 4'd0 : 4'd2));
            end
          end
        end
        S_READ: begin
          if (i_flush) begin
            state     <= S_IDLE;
            o_csr_req <= 1'b0;
          end else if (i_csr_ack) begin
            if (i_csr_err) begin
              state     <= S_DONE;
              o_csr_req <= 1'b0;
              done_q    <= 1'b1;
              trap_q    <= 1'b1;
              cause_q   <= 4'd2;
            end else begin
              o_rd_data <= i_csr_rdata;
              if (need_wr_q) begin
                state       <= S_WRITE;
                cnt         <= '0;
                o_csr_we    <= 1'b1;
                o_csr_wdata <= rmw(kind_q, i_csr_rdata, op_q);
              end else begin
                state     <= S_DONE;
                o_csr_req <= 1'b0;
                done_q    <= 1'b1;
                rd_we_q   <= (o_rd_addr != 5'd0);
              end
            end
          end else if (expire) begin
            state     <= S_DONE;
            o_csr_req <= 1'b0;
            done_q    <= 1'b1;
            trap_q    <= 1'b1;
            cause_q   <= 4'd2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WRITE: begin
          // A write cannot be abandoned once issued; a flush only hides its completion.
          if (i_flush) flush_pending <= 1'b1;
          if (i_csr_ack || expire) begin
            o_csr_req <= 1'b0;
            o_csr_we  <= 1'b0;
            if (flush_pending || i_flush) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DONE;
              done_q  <= 1'b1;
              trap_q  <= !i_csr_ack || i_csr_err;
              cause_q <= (!i_csr_ack || i_csr_err) ? 4'd2 : 4'd0;
              rd_we_q <= i_csr_ack && !i_csr_err && (o_rd_addr != 5'd0);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WFI: begin
          if (i_flush) begin
            state <= S_IDLE;
          end else if (i_irq_pending) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          done_q  <= 1'b0;
          trap_q  <= 1'b0;
          mret_q  <= 1'b0;
          rd_we_q <= 1'b0;
          cause_q <= 4'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sysop_unit.sv
// Directed bench for sysop_unit: inputs driven and outputs sampled on the falling edge.
module tb_sysop_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid, ready, flush, irq;
  logic [31:0] inst, rs1_data;
  logic        done, rd_we, trap, mret, wfi;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  cause;
  logic        csr_req, csr_we, csr_ack, csr_err;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sysop_unit #(.XLEN(32), .ENABLE_WFI(1'b1), .CSR_TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_inst(inst),
    .i_rs1_data(rs1_data), .i_flush(flush), .i_irq_pending(irq), .o_done(done),
    .o_rd_we(rd_we), .o_rd_addr(rd_addr), .o_rd_data(rd_data), .o_trap(trap),
    .o_cause(cause), .o_mret(mret), .o_wfi(wfi), .o_csr_req(csr_req), .o_csr_we(csr_we),
    .o_csr_addr(csr_addr), .o_csr_wdata(csr_wdata), .i_csr_ack(csr_ack),
    .i_csr_rdata(csr_rdata), .i_csr_err(csr_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one instruction for a single accepting cycle; returns at cycle T+1.
  task automatic issue(input logic [31:0] w, input logic [31:0] rs1);
    valid = 1'b1; inst = w; rs1_data = rs1;
    tick();
    valid = 1'b0;
  endtask

  task automatic single(input string tag, input logic [31:0] w, input logic [31:0] e_trap,
                        input logic [31:0] e_cause, input logic [31:0] e_mret);
    issue(w, 32'h0);
    chk({tag, "_done"},  32'(done), 1);
    chk({tag, "_trap"},  32'(trap), e_trap);
    chk({tag, "_cause"}, 32'(cause), e_cause);
    chk({tag, "_mret"},  32'(mret), e_mret);
    tick();
  endtask

  initial begin
    int  n;
    bit  seen;
    logic [31:0] t_trap, t_cause;

    rst = 1'b1; valid = 1'b0; flush = 1'b0; irq = 1'b0; inst = '0; rs1_data = '0;
    csr_ack = 1'b0; csr_err = 1'b0; csr_rdata = '0;
    tick(); tick();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_req",   32'(csr_req), 0);
    chk("rst_wfi",   32'(wfi), 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(ready), 1);

    // CSRRS x5, mstatus, x6 with x6=8
    issue(32'h3003_22F3, 32'h8);
    chk("rs_rd_req",  32'(csr_req), 1);
    chk("rs_rd_we",   32'(csr_we), 0);
    chk("rs_addr",    32'(csr_addr), 32'h300);
    chk("rs_ready",   32'(ready), 0);
    csr_ack = 1'b1; csr_rdata = 32'h1800;
    tick();
    csr_ack = 1'b0;
    chk("rs_wr_req",  32'(csr_req), 1);
    chk("rs_wr_we",   32'(csr_we), 1);
    chk("rs_wdata",   csr_wdata, 32'h1808);
    csr_ack = 1'b1;
    tick();
    csr_ack = 1'b0;
    chk("rs_done",    32'(done), 1);
    chk("rs_rdwe",    32'(rd_we), 1);
    chk("rs_rdaddr",  32'(rd_addr), 5);
    chk("rs_rddata",  rd_data, 32'h1800);
    chk("rs_trap",    32'(trap), 0);
    chk("rs_req_off", 32'(csr_req), 0);
    tick();
    chk("rs_done_1cy", 32'(done), 0);
    chk("rs_ready_back", 32'(ready), 1);

    // CSRRW x0, 0x305, x1 with x1=0x100: write only
    issue(32'h3050_9073, 32'h100);
    chk("rw_req",   32'(csr_req), 1);
    chk("rw_we",    32'(csr_we), 1);
    chk("rw_wdata", csr_wdata, 32'h100);
    chk("rw_addr",  32'(csr_addr), 32'h305);
    csr_ack = 1'b1;
    tick();
    csr_ack = 1'b0;
    chk("rw_done",  32'(done), 1);
    chk("rw_rdwe",  32'(rd_we), 0);
    tick();

    // CSRRCI x3, 0x344, 0: read only
    issue(32'h3440_71F3, 32'hDEAD);
    chk("rci_req",  32'(csr_req), 1);
    chk("rci_we",   32'(csr_we), 0);
    csr_ack = 1'b1; csr_rdata = 32'hA5A5;
    tick();
    csr_ack = 1'b0;
    chk("rci_done",   32'(done), 1);
    chk("rci_no_wr",  32'(csr_req), 0);
    chk("rci_rdwe",   32'(rd_we), 1);
    chk("rci_rdaddr", 32'(rd_addr), 3);
    chk("rci_rddata", rd_data, 32'hA5A5);
    tick();

    // Timeout: ack never arrives
    issue(32'h3003_22F3, 32'h8);
    n = 0; seen = 1'b0; t_trap = '0; t_cause = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (csr_req) n++;
      if (done) begin
        seen = 1'b1; t_trap = 32'(trap); t_cause = 32'(cause);
      end else tick();
    end
    chk("to_seen",   32'(seen), 1);
    chk("to_cycles", 32'(n), 16);
    chk("to_trap",   t_trap, 1);
    chk("to_cause",  t_cause, 2);
    tick();

    single("ecall",  32'h0000_0073, 1, 11, 0);
    single("ebreak", 32'h0010_0073, 1, 3, 0);
    single("mret",   32'h3020_0073, 0, 0, 1);
    single("illeg",  32'hFFFF_FFFF, 1, 2, 0);

    // WFI woken after five parked cycles
    issue(32'h1050_0073, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("wfi_park%0d", i), 32'(wfi), 1);
      chk($sformatf("wfi_nodone%0d", i), 32'(done), 0);
      if (i == 5) irq = 1'b1;
      if (i < 5) tick();
    end
    tick();
    irq = 1'b0;
    chk("wfi_off",  32'(wfi), 0);
    chk("wfi_done", 32'(done), 1);
    chk("wfi_trap", 32'(trap), 0);
    chk("wfi_rdwe", 32'(rd_we), 0);
    tick();

    // Flush during WRITE: write still completes, completion hidden
    issue(32'h3050_9073, 32'h77);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_req_held", 32'(csr_req), 1);
    chk("fl_wdata",    csr_wdata, 32'h77);
    csr_ack = 1'b1;
    tick();
    csr_ack = 1'b0;
    chk("fl_no_done", 32'(done), 0);
    chk("fl_req_off", 32'(csr_req), 0);
    chk("fl_idle",    32'(ready), 1);
    tick();
    chk("fl_no_done2", 32'(done), 0);

    // Flush with valid in IDLE: not accepted
    valid = 1'b1; inst = 32'h0000_0073; flush = 1'b1;
    #1;
    chk("flv_ready", 32'(ready), 0);
    tick();
    valid = 1'b0; flush = 1'b0;
    chk("flv_done", 32'(done), 0);
    chk("flv_req",  32'(csr_req), 0);
    tick();

    // Reset in the middle of a read
    issue(32'h3003_22F3, 32'h8);
    chk("mr_req", 32'(csr_req), 1);
    rst = 1'b1;
    #1;
    chk("mr_req_drop", 32'(csr_req), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_done", 32'(done), 0);
    chk("mr_ready", 32'(ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
